// File: rtl/stopwatch_bcd_counter_if.sv
// Control and display bundle of the MM:SS stopwatch.
// The lap input exists only when STOPWATCH_LAP_HOLD_EN is defined.
interface stopwatch_bcd_counter_if;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic       lap;
`endif
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       wrap;

  modport master (
`ifdef STOPWATCH_LAP_HOLD_EN
    output lap,
`endif
    output tick_in, start_stop, clear,
    input  sec_ones, sec_tens, min_ones, min_tens, running, wrap
  );

  modport slave (
`ifdef STOPWATCH_LAP_HOLD_EN
    input  lap,
`endif
    input  tick_in, start_stop, clear,
    output sec_ones, sec_tens, min_ones, min_tens, running, wrap
  );
endinterface

// File: rtl/stopwatch_bcd_counter.sv
// Start/stop/clear MM:SS stopwatch advanced by a synchronised 1 Hz tick_in edge.
// Define STOPWATCH_LAP_HOLD_EN to add the lap/hold display freeze.
module stopwatch_bcd_counter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_LIMIT   = 60
) (
  input logic                   clk_in,
  input logic                   rst,
  stopwatch_bcd_counter_if.slave sw
);

  localparam logic [3:0] MinTensLast = 4'((MIN_LIMIT - 1) / 10);
  localparam logic [3:0] MinOnesLast = 4'((MIN_LIMIT - 1) % 10);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, ss_q;
  logic [3:0]             sec_ones_q, sec_ones_d, sec_tens_q, sec_tens_d;
  logic [3:0]             min_ones_q, min_ones_d, min_tens_q, min_tens_d;
  logic                   wrap_q, wrap_d;
  logic                   tick, ss_edge;
  logic [15:0]            live_q, live_d, disp;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], sw.tick_in};
  assign tick    = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign ss_edge = sw.start_stop & ~ss_q;
  assign live_q  = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
  assign live_d  = {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d};

  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    if (sw.clear) begin
      state_d    = StIdle;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ss_edge) state_d = StRun;
        end
        StRun: begin
          // A tick landing with the pause edge still counts.
          if (tick) begin
            if (sec_ones_q != 4'd9) begin
              sec_ones_d = sec_ones_q + 4'd1;
            end else begin
              sec_ones_d = 4'd0;
              if (sec_tens_q != 4'd5) begin
                sec_tens_d = sec_tens_q + 4'd1;
              end else begin
                sec_tens_d = 4'd0;
                if (min_tens_q == MinTensLast && min_ones_q == MinOnesLast) begin
                  min_ones_d = 4'd0;
                  min_tens_d = 4'd0;
                  wrap_d     = 1'b1;
                end else if (min_ones_q == 4'd9) begin
                  min_ones_d = 4'd0;
                  min_tens_d = min_tens_q + 4'd1;
                end else begin
                  min_ones_d = min_ones_q + 4'd1;
                end
              end
            end
          end
          if (ss_edge) state_d = StPause;
        end
        StPause: begin
          if (ss_edge) state_d = StRun;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      hist_q     <= 1'b0;
      ss_q       <= 1'b0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hist_q     <= sync_q[SYNC_STAGES-1];
      ss_q       <= sw.start_stop;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      wrap_q     <= wrap_d;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        lap_q, hold_q, hold_d, lap_edge;
  logic [15:0] disp_q, disp_d;

  assign lap_edge = sw.lap & ~lap_q;

  always_comb begin
    hold_d = hold_q;
    disp_d = hold_q ? disp_q : live_d;
    if (sw.clear) begin
      hold_d = 1'b0;
      disp_d = live_d;
    end else if (state_q == StRun && lap_edge) begin
      // First edge freezes the pre-edge count; second edge releases to live.
      hold_d = ~hold_q;
      disp_d = hold_q ? live_d : live_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      lap_q  <= 1'b0;
      hold_q <= 1'b0;
      disp_q <= '0;
    end else begin
      lap_q  <= sw.lap;
      hold_q <= hold_d;
      disp_q <= disp_d;
    end
  end

  assign disp = disp_q;
`else
  assign disp = live_q;
`endif

  assign sw.min_tens = disp[15:12];
  assign sw.min_ones = disp[11:8];
  assign sw.sec_tens = disp[7:4];
  assign sw.sec_ones = disp[3:0];
  assign sw.running  = (state_q == StRun);
  assign sw.wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: seconds-level model checked every cycle plus directed literals.
module tb_stopwatch_bcd_counter;
  localparam int S  = 2;
  localparam int ML = 60;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_in = ~clk_in;

  stopwatch_bcd_counter_if sw_if ();

  stopwatch_bcd_counter #(
    .SYNC_STAGES(S),
    .MIN_LIMIT  (ML)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .sw    (sw_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] disp();
    return {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones};
  endfunction

  // Model: elapsed seconds as one integer, state as 0 idle / 1 run / 2 pause.
  int m_secs = 0, m_state = 0, m_held = 0;
  bit m_wrap = 0, m_hold = 0, m_ss = 0, m_lap = 0, cmp_en = 0;
  bit smp[0:S];  // smp[i]: tick_in as sampled i+1 edges ago

  always @(posedge clk_in) begin
    bit tk, sse, lpe;
    int st, pre;
    if (rst) begin
      m_secs = 0; m_state = 0; m_wrap = 0; m_hold = 0; m_ss = 0; m_lap = 0;
      for (int i = 0; i <= S; i++) smp[i] = 0;
      cmp_en = 1;
    end else begin
      tk = smp[S-1] && !smp[S];
      for (int i = S; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = sw_if.tick_in;
      sse  = sw_if.start_stop && !m_ss;
      m_ss = sw_if.start_stop;
      st   = m_state;
      pre  = m_secs;
      m_wrap = 0;
      if (sw_if.clear) begin
        m_state = 0; m_secs = 0; m_hold = 0;
      end else begin
        if (st == 1 && tk) begin
          m_secs = (m_secs + 1) % (ML * 60);
          m_wrap = (m_secs == 0);
        end
        if (sse) m_state = (st == 1) ? 2 : 1;
      end
`ifdef STOPWATCH_LAP_HOLD_EN
      lpe   = sw_if.lap && !m_lap;
      m_lap = sw_if.lap;
      if (!sw_if.clear && st == 1 && lpe) begin
        if (!m_hold) begin m_hold = 1; m_held = pre; end
        else m_hold = 0;
      end
`else
      lpe = 0;
`endif
    end
  end

  always @(negedge clk_in) begin
    int d;
    if (cmp_en) begin
      d = m_hold ? m_held : m_secs;
      chk("sec_ones", sw_if.sec_ones, d % 10);
      chk("sec_tens", sw_if.sec_tens, (d / 10) % 6);
      chk("min_ones", sw_if.min_ones, (d / 60) % 10);
      chk("min_tens", sw_if.min_tens, d / 600);
      chk("running",  sw_if.running, (m_state == 1));
      chk("wrap",     sw_if.wrap, m_wrap);
    end
  end

  task automatic tick_with(input bit ss, input bit clr);
    @(negedge clk_in) sw_if.tick_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in) begin sw_if.start_stop = ss; sw_if.clear = clr; end
    @(negedge clk_in) begin sw_if.start_stop = 1'b0; sw_if.clear = 1'b0; sw_if.tick_in = 1'b0; end
    @(negedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_with(1'b0, 1'b0);
  endtask

  task automatic start_pulse();
    @(negedge clk_in) sw_if.start_stop = 1'b1;
    @(negedge clk_in) sw_if.start_stop = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk_in) sw_if.clear = 1'b1;
    @(negedge clk_in) sw_if.clear = 1'b0;
  endtask

`ifdef STOPWATCH_LAP_HOLD_EN
  task automatic lap_pulse();
    @(negedge clk_in) sw_if.lap = 1'b1;
    @(negedge clk_in) sw_if.lap = 1'b0;
  endtask
`endif

  initial begin
    sw_if.tick_in = 1'b0; sw_if.start_stop = 1'b0; sw_if.clear = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
    sw_if.lap = 1'b0;
`endif
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    chk("rst_disp", disp(), 16'h0000);
    chk("rst_running", sw_if.running, 1'b0);
    chk("rst_wrap", sw_if.wrap, 1'b0);

    ticks(3);
    chk("idle_disp", disp(), 16'h0000);
    chk("idle_running", sw_if.running, 1'b0);

    start_pulse();
    chk("start_running", sw_if.running, 1'b1);

    // Increment must land on the third edge after tick_in rises.
    @(negedge clk_in) sw_if.tick_in = 1'b1;
    @(posedge clk_in) #1 chk("lat_e1", disp(), 16'h0000);
    @(posedge clk_in) #1 chk("lat_e2", disp(), 16'h0000);
    @(posedge clk_in) #1 chk("lat_e3", disp(), 16'h0001);
    @(negedge clk_in) sw_if.tick_in = 1'b0;
    repeat (2) @(negedge clk_in);
    ticks(2);
    chk("cnt_0003", disp(), 16'h0003);

    ticks(56);
    chk("cnt_0059", disp(), 16'h0059);
    ticks(1);
    chk("cnt_0100", disp(), 16'h0100);
    ticks(3539);
    chk("cnt_5959", disp(), 16'h5959);

    @(negedge clk_in) sw_if.tick_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("wrap_disp", disp(), 16'h0000);
    chk("wrap_hi", sw_if.wrap, 1'b1);
    @(posedge clk_in) #1 chk("wrap_lo", sw_if.wrap, 1'b0);
    chk("wrap_still_run", sw_if.running, 1'b1);
    @(negedge clk_in) sw_if.tick_in = 1'b0;
    repeat (2) @(negedge clk_in);

    clear_pulse();
    chk("clr_running", sw_if.running, 1'b0);
    start_pulse();
    ticks(5);
    chk("cnt_0005", disp(), 16'h0005);
    tick_with(1'b1, 1'b0);
    chk("pause_tick_disp", disp(), 16'h0006);
    chk("pause_running", sw_if.running, 1'b0);
    ticks(2);
    chk("paused_held", disp(), 16'h0006);
    start_pulse();
    chk("resume_running", sw_if.running, 1'b1);
    ticks(1);
    chk("cnt_0007", disp(), 16'h0007);

    ticks(747);
    chk("cnt_1234", disp(), 16'h1234);
    tick_with(1'b0, 1'b1);
    chk("clr_tick_disp", disp(), 16'h0000);
    chk("clr_tick_running", sw_if.running, 1'b0);
    ticks(1);
    chk("idle_after_clr", disp(), 16'h0000);

`ifdef STOPWATCH_LAP_HOLD_EN
    start_pulse();
    ticks(10);
    lap_pulse();
    ticks(5);
    chk("lap_frozen", disp(), 16'h0010);
    lap_pulse();
    chk("lap_live", disp(), 16'h0015);
`endif

    repeat (2) @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
